// File: rtl/blur_pixel_feeder.sv
// blur_pixel_feeder: reads one grayscale frame in raster order from a
// synchronous-read frame RAM and streams it as valid-qualified 8-bit pixels
// into the gaussian_blur engine. A programmable gap of H_BLANK idle cycles
// separates consecutive lines, and frame_done pulses once the last pixel
// has left the pipeline.
//
// Optional feature macro: FEEDER_TPG_EN
//   When defined, adds the tpg_en input. tpg_en is captured at frame start;
//   if set, the frame is a (row + col) mod 256 test pattern, no RAM reads are
//   issued, and the pixel_vld_out timing matches a RAM frame exactly.
//
// Handshake: there is no backpressure. pixel_vld_out qualifies pixel_out
// on every cycle it is high, and the consumer must accept that beat.
// mem_rdata is taken exactly one cycle after mem_rd is high.
module blur_pixel_feeder #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int H_BLANK = 4,
  parameter int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pixel_out,
  output logic              pixel_vld_out,
  output logic              busy,
  output logic              frame_done
`ifdef FEEDER_TPG_EN
  ,
  input  logic              tpg_en
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    BLANK = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       col, col_nxt;
  logic [RW-1:0]       row, row_nxt;
  logic [BW-1:0]       blank_cnt, blank_nxt;
  logic [1:0]          flush_cnt, flush_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [ADDR_W-1:0]   addr_step;
  logic                tpg_mode, tpg_nxt;
  logic                rd_slot;
  logic [7:0]          tpg_pix;
  logic                vld_s1;
  logic [7:0]          tpg_pix_s1;

  // A pixel slot is every LINE cycle; it drives a RAM read only for RAM frames.
  assign rd_slot    = (state == LINE);
  assign mem_rd     = rd_slot && !tpg_mode;
  assign busy       = (state != IDLE);
  // Third FLUSH cycle: the last beat was on the previous cycle.
  assign frame_done = (state == FLUSH) && (flush_cnt == 2'd2);
  assign tpg_pix    = 8'(row) + 8'(col);
  // Address only advances when reads are actually issued, so it holds in TPG frames.
  assign addr_step  = tpg_mode ? mem_addr : mem_addr + ADDR_W'(1);

  // FSM state and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
      flush_cnt <= '0;
      mem_addr  <= '0;
      tpg_mode  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      blank_cnt <= blank_nxt;
      flush_cnt <= flush_nxt;
      mem_addr  <= addr_nxt;
      tpg_mode  <= tpg_nxt;
    end
  end

  // Next-state logic: raster scan with line blanking and a read-pipe drain.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    blank_nxt = blank_cnt;
    flush_nxt = flush_cnt;
    addr_nxt  = mem_addr;
    tpg_nxt   = tpg_mode;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LINE;
          col_nxt   = '0;
          row_nxt   = '0;
          addr_nxt  = '0;
`ifdef FEEDER_TPG_EN
          tpg_nxt   = tpg_en;
`endif
        end
      end
      LINE: begin
        if (col == COL_LAST) begin
          if (row == ROW_LAST) begin
            // Last pixel issued; the address stays on it through the drain.
            state_nxt = FLUSH;
            flush_nxt = '0;
          end else begin
            col_nxt = '0;
            row_nxt = row + RW'(1);
            if (H_BLANK == 0) begin
              addr_nxt = addr_step;
            end else begin
              // Address holds on the line's last pixel through the blanking gap.
              state_nxt = BLANK;
              blank_nxt = '0;
            end
          end
        end else begin
          col_nxt  = col + CW'(1);
          addr_nxt = addr_step;
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          state_nxt = LINE;
          addr_nxt  = addr_step;
        end else begin
          blank_nxt = blank_cnt + BW'(1);
        end
      end
      FLUSH: begin
        if (flush_cnt == 2'd2) begin
          state_nxt = IDLE;
        end else begin
          flush_nxt = flush_cnt + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Two-stage valid pipe; pixel captured from RAM (or pattern) when stage 1 is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1        <= 1'b0;
      tpg_pix_s1    <= '0;
      pixel_vld_out <= 1'b0;
      pixel_out     <= '0;
    end else begin
      vld_s1        <= rd_slot;
      tpg_pix_s1    <= tpg_pix;
      pixel_vld_out <= vld_s1;
      if (vld_s1) begin
        pixel_out <= tpg_mode ? tpg_pix_s1 : mem_rdata;
      end
    end
  end

endmodule

// File: doc/blur_pixel_feeder.md
# blur_pixel_feeder

Frame source for the `gaussian_blur` engine. Reads one grayscale frame in raster order from a synchronous-read frame RAM and drives it as an 8-bit valid-qualified pixel stream into the blur's `pixel_in`/`pixel_vld` inputs. Inserts a programmable horizontal blanking gap between lines. Signals frame completion so the controller can start the next frame.

## Interface
- `IMG_W`, 64, pixels per line (>= 2)
- `IMG_H`, 64, lines per frame (>= 2)
- `H_BLANK`, 4, idle cycles inserted between consecutive lines (0 allowed)
- `ADDR_W`, `$clog2(IMG_W*IMG_H)`, frame RAM address width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  frame request; sampled only in IDLE
- `mem_rd`  out  1  RAM read enable
- `mem_addr`  out  ADDR_W  RAM read address, `row*IMG_W + col`
- `mem_rdata`  in  8  RAM read data, valid one cycle after `mem_rd`
- `tpg_en`  in  1  test-pattern select (present only with `FEEDER_TPG_EN`)
- `pixel_out`  out  8  pixel to blur `pixel_in`
- `pixel_vld_out`  out  1  qualifier to blur `pixel_vld`
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LINE, BLANK, FLUSH.
- IDLE: `start`=1 clears row and col to 0, enters LINE, sets `busy`.
- LINE: `mem_rd`=1 with `mem_addr` = current pixel; col increments each cycle. At col = IMG_W-1:
  - not last row: col <= 0, row++, go BLANK (or stay in LINE if H_BLANK=0).
  - last row: go FLUSH.
- BLANK: `mem_rd`=0 for exactly H_BLANK cycles, then LINE.
- FLUSH: `mem_rd`=0 for 2 cycles to drain the read pipeline. Then assert `frame_done` for one cycle, clear `busy`, return to IDLE.
- Data path:
  - `mem_rd` is delayed through a 2-stage valid pipe to `pixel_vld_out`.
  - `pixel_out` is registered from `mem_rdata` when stage-1 valid is set.
  - `pixel_out` holds its last value when not valid.
- `start` while busy is ignored; there is no queuing.
- `mem_addr` holds its last value while `mem_rd`=0.
- Address arithmetic is an ADDR_W-bit incrementing counter. It is never wrapped mid-frame, and it resets to 0 at each frame start.

## Timing
- Reset (async assert, sync release): `mem_rd`=0, `mem_addr`=0, `pixel_out`=0, `pixel_vld_out`=0, `busy`=0, `frame_done`=0, state IDLE. In-flight read data is discarded.
- `start` high at edge E0 gives `busy`=1 and `mem_rd`=1 after E0. The first `pixel_vld_out`=1 follows E2, so there is a fixed 2-cycle latency from `mem_rd` to `pixel_vld_out`.
- `pixel_vld_out` is exactly `mem_rd` delayed by 2 cycles; the blanking pattern is preserved.
- Frame active span is IMG_W*IMG_H + (IMG_H-1)*H_BLANK cycles of `mem_rd` window.
- `frame_done` is high in the cycle immediately after the last `pixel_vld_out`. `busy` falls on the same edge that deasserts `frame_done`.
- Earliest next `start` acceptance: the cycle after `frame_done`.
- Reset mid-frame: outputs go to reset values immediately. No `frame_done` is produced.

## Configuration
- `FEEDER_TPG_EN` defined:
  - adds the `tpg_en` port, sampled at `start` and held for the frame.
  - If set, `pixel_out` = (row + col) mod 256 and `mem_rd` stays 0. `pixel_vld_out` timing is identical to a RAM frame.
- Not defined: no `tpg_en` port; pixels always come from RAM.

## Test plan
Use IMG_W=4, IMG_H=3, H_BLANK=2 unless noted.
- Reset: assert `rst_n`=0 with `start` toggling -> all outputs 0, no `mem_rd`.
- Single frame, RAM[a]=a+0x10:
  - addresses 0..11 issued over 16 cycles with 2-cycle gaps after addr 3 and 7.
  - `pixel_out` sequence 0x10..0x1B, each 2 cycles after its address.
  - `frame_done` 1 cycle after the 0x1B beat.
- `start` pulsed during a frame -> ignored; exactly 12 valid beats and one `frame_done`. `start` the cycle after `frame_done` -> new frame from addr 0.
- H_BLANK=0 -> 12 contiguous `pixel_vld_out` cycles.
- `rst_n` low after 5 valid beats -> outputs 0 asynchronously, no `frame_done`. A later `start` restarts at addr 0.
- `FEEDER_TPG_EN` with `tpg_en`=1 -> `mem_rd` never high; row 1 col 2 beat = 0x03, last beat = 0x05.
